// File: rtl/smart_toilet_dispense_ctrl.sv
// Staggered three-pump dispense sequencer with settle wait and outlet-sample sum/peak capture.
// Latency: pumps react one cycle after start; every stage lasts exactly its latched duration.
// Backpressure: sens_ready is high only in SAMPLE; sample collection waits on sens_valid indefinitely.
module smart_toilet_dispense_ctrl #(
  parameter int SENS_W = 12,
  parameter int CNT_W  = 16,
  parameter int ACC_W  = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  lead3_cyc,
  input  logic [CNT_W-1:0]  lead2_cyc,
  input  logic [CNT_W-1:0]  pump_cyc,
  input  logic [CNT_W-1:0]  settle_cyc,
  input  logic [7:0]        nsamp,
  output logic              pump1_en,
  output logic              pump2_en,
  output logic              pump3_en,
  input  logic              sens_valid,
  input  logic [SENS_W-1:0] sens_data,
  output logic              sens_ready,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [ACC_W-1:0]  result_sum,
  output logic [SENS_W-1:0] result_peak
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRIME3   = 3'd1,
    PRIME2   = 3'd2,
    DISPENSE = 3'd3,
    SETTLE   = 3'd4,
    SAMPLE   = 3'd5,
    FINISH   = 3'd6
  } state_t;

  state_t           state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic [CNT_W-1:0] l3_q, l2_q, pmp_q, stl_q;
  logic [7:0]       ns_q;
  logic             take;

  // First stage at or after 'from' whose duration is non-zero; FINISH if none remain.
  function automatic state_t first_stage(input logic [2:0] from,
                                         input logic [CNT_W-1:0] d3, input logic [CNT_W-1:0] d2,
                                         input logic [CNT_W-1:0] dp, input logic [CNT_W-1:0] ds,
                                         input logic [7:0] n);
    state_t s;
    s = FINISH;
    if (from <= 3'd5 && n  != 8'd0) s = SAMPLE;
    if (from <= 3'd4 && ds != '0)   s = SETTLE;
    if (from <= 3'd3 && dp != '0)   s = DISPENSE;
    if (from <= 3'd2 && d2 != '0)   s = PRIME2;
    if (from <= 3'd1 && d3 != '0)   s = PRIME3;
    return s;
  endfunction

  // Counter load value for a stage: cycles for timed stages, sample count for SAMPLE.
  function automatic logic [CNT_W-1:0] stage_len(input state_t s,
                                                 input logic [CNT_W-1:0] d3, input logic [CNT_W-1:0] d2,
                                                 input logic [CNT_W-1:0] dp, input logic [CNT_W-1:0] ds,
                                                 input logic [7:0] n);
    logic [CNT_W-1:0] v;
    case (s)
      PRIME3:   v = d3;
      PRIME2:   v = d2;
      DISPENSE: v = dp;
      SETTLE:   v = ds;
      SAMPLE:   v = {{(CNT_W-8){1'b0}}, n};
      default:  v = '0;
    endcase
    return v;
  endfunction

  assign take = sens_ready & sens_valid;

  // Next-state and stage-counter selection; abort overrides everything outside IDLE.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          nxt_state = first_stage(3'd1, lead3_cyc, lead2_cyc, pump_cyc, settle_cyc, nsamp);
          nxt_cnt   = stage_len(nxt_state, lead3_cyc, lead2_cyc, pump_cyc, settle_cyc, nsamp);
        end
      end
      PRIME3, PRIME2, DISPENSE, SETTLE: begin
        if (cnt == CNT_W'(1)) begin
          nxt_state = first_stage(3'(state) + 3'd1, l3_q, l2_q, pmp_q, stl_q, ns_q);
          nxt_cnt   = stage_len(nxt_state, l3_q, l2_q, pmp_q, stl_q, ns_q);
        end else begin
          nxt_cnt = cnt - 1'b1;
        end
      end
      SAMPLE: begin
        if (take) begin
          if (cnt == CNT_W'(1)) begin
            nxt_state = FINISH;
            nxt_cnt   = '0;
          end else begin
            nxt_cnt = cnt - 1'b1;
          end
        end
      end
      FINISH:  nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
    if (abort && state != IDLE) nxt_state = IDLE;
  end

  // State, latched durations, results and all registered outputs derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      l3_q        <= '0;
      l2_q        <= '0;
      pmp_q       <= '0;
      stl_q       <= '0;
      ns_q        <= '0;
      pump1_en    <= 1'b0;
      pump2_en    <= 1'b0;
      pump3_en    <= 1'b0;
      sens_ready  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      result_sum  <= '0;
      result_peak <= '0;
    end else begin
      state      <= nxt_state;
      cnt        <= nxt_cnt;
      pump3_en   <= (nxt_state == PRIME3) || (nxt_state == PRIME2) || (nxt_state == DISPENSE);
      pump2_en   <= (nxt_state == PRIME2) || (nxt_state == DISPENSE);
      pump1_en   <= (nxt_state == DISPENSE);
      sens_ready <= (nxt_state == SAMPLE);
      busy       <= (nxt_state != IDLE);
      done       <= (nxt_state == FINISH);
      aborted    <= abort && (state != IDLE);
      if (state == IDLE && start) begin
        l3_q        <= lead3_cyc;
        l2_q        <= lead2_cyc;
        pmp_q       <= pump_cyc;
        stl_q       <= settle_cyc;
        ns_q        <= nsamp;
        result_sum  <= '0;
        result_peak <= '0;
      end else if (take) begin
        result_sum <= result_sum + ACC_W'(sens_data);
        if (sens_data > result_peak) result_peak <= sens_data;
      end
    end
  end

endmodule

// File: tb/tb_smart_toilet_dispense_ctrl.sv
// Randomised and directed bench for smart_toilet_dispense_ctrl against a timeline-based model.
module tb_smart_toilet_dispense_ctrl;
  localparam int SENS_W = 12;
  localparam int CNT_W  = 16;
  localparam int ACC_W  = 20;

  localparam int R_IDLE = 0, R_P3 = 1, R_P2 = 2, R_DISP = 3, R_SETL = 4, R_SAMP = 5, R_FIN = 6;

  logic clk = 1'b0;
  logic rst;
  logic start, abort;
  logic [CNT_W-1:0] lead3_cyc, lead2_cyc, pump_cyc, settle_cyc;
  logic [7:0] nsamp;
  logic pump1_en, pump2_en, pump3_en;
  logic sens_valid;
  logic [SENS_W-1:0] sens_data;
  logic sens_ready, busy, done, aborted;
  logic [ACC_W-1:0] result_sum;
  logic [SENS_W-1:0] result_peak;

  int n_cmp = 0;
  int n_bad = 0;

  smart_toilet_dispense_ctrl #(.SENS_W(SENS_W), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .lead3_cyc(lead3_cyc), .lead2_cyc(lead2_cyc), .pump_cyc(pump_cyc), .settle_cyc(settle_cyc),
    .nsamp(nsamp), .pump1_en(pump1_en), .pump2_en(pump2_en), .pump3_en(pump3_en),
    .sens_valid(sens_valid), .sens_data(sens_data), .sens_ready(sens_ready),
    .busy(busy), .done(done), .aborted(aborted),
    .result_sum(result_sum), .result_peak(result_peak)
  );

  always #5 clk = ~clk;

  // Model: a run is a timeline t = cycles since the start edge plus a count k of accepted samples.
  bit m_run, m_abt;
  int m_t, m_k, m_l3, m_l2, m_p, m_s, m_n, m_sum, m_peak;

  function automatic int region();
    int tt;
    if (!m_run) return R_IDLE;
    tt = m_t;
    if (tt <= m_l3) return R_P3;
    tt -= m_l3;
    if (tt <= m_l2) return R_P2;
    tt -= m_l2;
    if (tt <= m_p) return R_DISP;
    tt -= m_p;
    if (tt <= m_s) return R_SETL;
    if (m_k < m_n) return R_SAMP;
    return R_FIN;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    int r;
    if (rst) begin
      m_run = 0; m_abt = 0; m_t = 0; m_k = 0; m_sum = 0; m_peak = 0;
      m_l3 = 0; m_l2 = 0; m_p = 0; m_s = 0; m_n = 0;
    end else begin
      r = region();
      m_abt = m_run && abort;
      if (r == R_SAMP && sens_valid) begin
        m_sum += int'(sens_data);
        if (int'(sens_data) > m_peak) m_peak = int'(sens_data);
        m_k++;
      end
      if (!m_run) begin
        if (start) begin
          m_l3 = int'(lead3_cyc); m_l2 = int'(lead2_cyc); m_p = int'(pump_cyc);
          m_s = int'(settle_cyc); m_n = int'(nsamp);
          m_run = 1; m_t = 1; m_k = 0; m_sum = 0; m_peak = 0;
        end
      end else if (abort || r == R_FIN) begin
        m_run = 0;
      end else begin
        m_t++;
      end
    end
  end

  // One clock cycle; at the falling edge every output is compared against the model.
  task automatic tick();
    logic [38:0] exp_v, act_v;
    int r;
    @(negedge clk);
    if (!rst) begin
      r = region();
      exp_v = {r == R_DISP, (r == R_P2) || (r == R_DISP), (r == R_P3) || (r == R_P2) || (r == R_DISP),
               r == R_SAMP, m_run, r == R_FIN, m_abt, ACC_W'(m_sum), SENS_W'(m_peak)};
      act_v = {pump1_en, pump2_en, pump3_en, sens_ready, busy, done, aborted, result_sum, result_peak};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL cycle_cmp at %0t: got p1p2p3/rdy/busy/done/abt=%b sum=%0d peak=%0d, want %b sum=%0d peak=%0d",
                 $time, act_v[38:32], act_v[31:12], act_v[11:0], exp_v[38:32], exp_v[31:12], exp_v[11:0]);
      end
    end
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  int nom[3] = '{100, 200, 50};
  int r_c1, r_c2, r_c3, r_ndone, r_done_at, r_nabt, r_abt_at, r_nhs, r_end, r_rdy_first;

  // Start a run now (caller is just past a falling edge) and drive it until busy drops.
  task automatic do_run(input int l3, input int l2, input int p, input int s, input int n,
                        input int vmode, input int abort_at, input int xstart_at);
    int idx;
    bit fin;
    idx = 0; fin = 0;
    r_c1 = 0; r_c2 = 0; r_c3 = 0; r_ndone = 0; r_done_at = 0; r_nabt = 0; r_abt_at = 0;
    r_nhs = 0; r_end = 0; r_rdy_first = 0;
    lead3_cyc = CNT_W'(l3); lead2_cyc = CNT_W'(l2); pump_cyc = CNT_W'(p);
    settle_cyc = CNT_W'(s); nsamp = 8'(n);
    start = 1'b1;
    abort = (abort_at < 0);
    for (int c = 1; c <= 4000; c++) begin
      tick();
      if (pump1_en) r_c1++;
      if (pump2_en) r_c2++;
      if (pump3_en) r_c3++;
      if (done) begin r_ndone++; r_done_at = c; end
      if (aborted) begin r_nabt++; r_abt_at = c; end
      if (sens_ready && r_rdy_first == 0) r_rdy_first = c;
      if (!busy) begin
        start = 0; abort = 0; sens_valid = 0; r_end = c; fin = 1;
        break;
      end
      start = (c == xstart_at);
      abort = (c == abort_at);
      case (vmode)
        0, 3:    sens_valid = 1'b1;
        1:       sens_valid = (((c - 1) % 5) != 1) && (((c - 1) % 5) != 2);
        default: sens_valid = 1'($urandom_range(0, 1));
      endcase
      if (vmode == 3)      sens_data = 12'd4095;
      else if (vmode == 0) sens_data = SENS_W'(nom[idx % 3]);
      else                 sens_data = SENS_W'($urandom_range(0, 4095));
      if (sens_ready && sens_valid) begin r_nhs++; idx++; end
    end
    if (!fin) begin
      n_cmp++; n_bad++;
      $display("FAIL run_timeout: got busy still high after 4000 cycles, want idle");
    end
  endtask

  task automatic check_nominal(input string tag);
    check({tag, "_pump3_cycles"}, r_c3, 12);
    check({tag, "_pump2_cycles"}, r_c2, 7);
    check({tag, "_pump1_cycles"}, r_c1, 4);
    check({tag, "_ready_first"}, r_rdy_first, 15);
    check({tag, "_done_count"}, r_ndone, 1);
    check({tag, "_done_at"}, r_done_at, 18);
    check({tag, "_idle_after_done"}, r_end, r_done_at + 1);
    check({tag, "_sum"}, result_sum, 350);
    check({tag, "_peak"}, result_peak, 200);
  endtask

  initial begin
    rst = 1'b1; start = 0; abort = 0; sens_valid = 0; sens_data = '0;
    lead3_cyc = '0; lead2_cyc = '0; pump_cyc = '0; settle_cyc = '0; nsamp = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {pump1_en, pump2_en, pump3_en, sens_ready, busy, done, aborted, result_sum, result_peak}, 0);
    rst = 1'b0;
    tick();

    // Nominal run.
    do_run(5, 3, 4, 2, 3, 0, 0, 0);
    check_nominal("nominal");

    // Abort in IDLE has no effect.
    abort = 1'b1; tick(); abort = 1'b0;
    check("idle_abort_no_pulse", {aborted, busy}, 0);

    // Zero-duration stages skipped.
    do_run(0, 0, 3, 0, 0, 0, 0, 0);
    check("zero_pump1_cycles", r_c1, 3);
    check("zero_pump3_cycles", r_c3, 3);
    check("zero_done_at", r_done_at, 4);
    check("zero_sum", result_sum, 0);
    check("zero_peak", result_peak, 0);

    // Sensor backpressure with valid pattern 1,0,0,1,1.
    do_run(1, 0, 0, 0, 3, 1, 0, 0);
    check("bp_handshakes", r_nhs, 3);
    check("bp_done_at", r_done_at, 7);

    // Abort mid-DISPENSE, then restart.
    do_run(5, 3, 4, 2, 3, 0, 10, 0);
    check("abort_pulses", r_nabt, 1);
    check("abort_at", r_abt_at, 11);
    check("abort_no_done", r_ndone, 0);
    check("abort_pump1_cycles", r_c1, 2);
    check("abort_idle_cycle", r_end, 11);
    do_run(5, 3, 4, 2, 3, 0, 0, 0);
    check_nominal("restart");

    // start while busy is ignored.
    do_run(5, 3, 4, 2, 3, 0, 0, 3);
    check_nominal("busy_start");

    // Simultaneous start and abort in IDLE: the run starts.
    do_run(2, 0, 0, 0, 0, 0, -1, 0);
    check("start_abort_done_at", r_done_at, 3);
    check("start_abort_no_abort", r_nabt, 0);

    // Asynchronous reset during PRIME2.
    lead3_cyc = 16'd5; lead2_cyc = 16'd3; pump_cyc = 16'd4; settle_cyc = 16'd2; nsamp = 8'd3;
    start = 1'b1; tick(); start = 1'b0;
    repeat (6) tick();
    check("prime2_pumps", {pump1_en, pump2_en, pump3_en}, 3);
    #2 rst = 1'b1;
    #1 check("async_reset_outputs",
             {pump1_en, pump2_en, pump3_en, sens_ready, busy, done, aborted, result_sum, result_peak}, 0);
    @(negedge clk); rst = 1'b0;
    tick();

    // Accumulator width at full scale.
    do_run(1, 1, 1, 1, 255, 3, 0, 0);
    check("sat_sum", result_sum, 1044225);
    check("sat_peak", result_peak, 4095);
    check("sat_handshakes", r_nhs, 255);

    // Randomised runs, often back-to-back.
    for (int i = 0; i < 30; i++) begin
      do_run($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3),
             $urandom_range(0, 4), 2,
             ($urandom_range(0, 9) < 3) ? $urandom_range(1, 15) : 0,
             ($urandom_range(0, 1) == 1) ? $urandom_range(1, 10) : 0);
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/smart_toilet_dispense_ctrl.md
Name: smart_toilet_dispense_ctrl

Overview:
- Electronic sequencer on the off-chip side of the smart-toilet mixing chip.
- Drives the three inlet pumps (soln1, soln2, soln3) in a staggered order so that each reagent front reaches its mixer together, despite the different serpentine delay paths.
- Waits for outlet transit, then collects a burst of outlet-sensor samples and reports their sum and peak.
- Sits between the host control register block and the pump drivers and ADC.

Parameters:
- SENS_W, 12, outlet sensor sample width.
- CNT_W, 16, width of the duration inputs and internal timer.
- ACC_W, 20, sum accumulator width (SENS_W+8; covers up to 255 samples with no overflow).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a run; ignored unless in IDLE.
- abort  input  1  terminate the current run immediately.
- lead3_cyc  input  CNT_W  soln3-only priming duration.
- lead2_cyc  input  CNT_W  soln3+soln2 priming duration.
- pump_cyc  input  CNT_W  all-three dispense duration.
- settle_cyc  input  CNT_W  pumps-off transit wait.
- nsamp  input  8  number of outlet samples to collect.
- pump1_en  output  1  soln1 pump drive.
- pump2_en  output  1  soln2 pump drive.
- pump3_en  output  1  soln3 pump drive.
- sens_valid  input  1  ADC sample valid.
- sens_data  input  SENS_W  ADC sample.
- sens_ready  output  1  controller accepts a sample.
- busy  output  1  high whenever the state is not IDLE.
- done  output  1  one-cycle pulse when a run completes normally.
- aborted  output  1  one-cycle pulse when a run is aborted.
- result_sum  output  ACC_W  sum of the collected samples.
- result_peak  output  SENS_W  maximum collected sample.

Behaviour:
- Reset: all outputs are 0; the state is IDLE; result_sum and result_peak are 0.
- All outputs are registered.
- States: IDLE, PRIME3, PRIME2, DISPENSE, SETTLE, SAMPLE, FINISH.
- On the edge where start=1 in IDLE:
  - The five duration inputs are latched.
  - The accumulators are cleared.
  - The FSM enters the first stage with a non-zero duration.
  - Stage order: PRIME3, PRIME2, DISPENSE, SETTLE, SAMPLE (SAMPLE uses nsamp).
  - If every duration is 0, the FSM goes directly to FINISH.
- Each timed stage lasts exactly N cycles, where N is its latched duration. A zero-duration stage is skipped with no extra cycle.
- Pump outputs by state:
  - PRIME3: pump3 only.
  - PRIME2: pump3 and pump2.
  - DISPENSE: pump1, pump2 and pump3.
  - All other states: all pumps off.
  - Pump outputs go high in the first cycle after the start edge.
- SAMPLE:
  - sens_ready=1 throughout the state.
  - A sample is accepted on each edge where sens_valid and sens_ready are both high.
  - On acceptance: sum += sample; peak = max(peak, sample).
  - The FSM leaves SAMPLE on the edge that accepts sample number nsamp.
  - Waiting for samples has no timeout; the host uses abort.
- sens_ready is 0 outside SAMPLE, so samples arriving then are dropped.
- FINISH lasts one cycle:
  - done=1 during that cycle.
  - The FSM returns to IDLE.
  - result_sum and result_peak hold until the next accepted start.
- abort=1 in any non-IDLE state:
  - Next cycle: state is IDLE, pumps are 0, sens_ready is 0, aborted pulses for one cycle.
  - done is not asserted.
  - The results retain their partial values.
  - abort in IDLE has no effect.
- Simultaneous start and abort in IDLE: abort is ignored and the run starts.
- start while busy is ignored; the latched durations do not change mid-run.
- Asynchronous reset mid-run: pumps drop immediately, without waiting for a clock edge.
- Accepted starts reaching FINISH back-to-back: a new start is accepted in the IDLE cycle that follows FINISH.

Test Plan:
- Nominal run: lead3=5, lead2=3, pump=4, settle=2, nsamp=3; samples 100, 200, 50 offered continuously.
  - pump3 high for 12 cycles, pump2 for 7, pump1 for 4; all pumps fall on the same edge.
  - After 2 settle cycles, sens_ready rises.
  - Final result: sum=350, peak=200; done pulses exactly once; busy is low on the next cycle.
- Zero stages: lead3=0, lead2=0, pump=3, settle=0, nsamp=0.
  - All three pumps are high for cycles 1 to 3 after start.
  - done pulses in cycle 4; sum=0, peak=0.
- Sensor backpressure: sens_valid toggles 1,0,0,1,1 with nsamp=3.
  - Exactly 3 samples are accepted; samples offered outside SAMPLE are not counted.
- Abort mid-DISPENSE (cycle 10 of the nominal run):
  - All pumps are 0 and aborted=1 on the next cycle; done is never asserted.
  - A restart then repeats the nominal run exactly.
- Reset asserted during PRIME2: pumps go to 0 asynchronously and all outputs read 0. start ignored while busy leaves the timing unchanged.
- Saturation width: nsamp=255 with every sample = 4095 gives sum=1044225 with no wrap and peak=4095.
